// File: rtl/move_request_arbiter_if.sv
// Move command handshake between the switch arbiter and game logic.
// master offers moves, slave accepts them with i_Move_Ready.
interface move_request_arbiter_if;
  logic       o_Move_Valid;
  logic [1:0] o_Move_Dir;
  logic       o_Move_Repeat;
  logic       i_Move_Ready;

  modport master (
    output o_Move_Valid,
    output o_Move_Dir,
    output o_Move_Repeat,
    input  i_Move_Ready
  );

  modport slave (
    input  o_Move_Valid,
    input  o_Move_Dir,
    input  o_Move_Repeat,
    output i_Move_Ready
  );
endinterface

// File: rtl/move_request_arbiter.sv
// Turns debounced direction switches into handshaked move commands.
// Define AUTO_REPEAT_EN to build the held-switch auto-repeat logic.
module move_request_arbiter #(
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int CNT_W        = 24
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic [3:0]                    i_Switch,
  input  logic                          i_Enable,
  move_request_arbiter_if.master        mv,
  output logic [3:0]                    o_Pending
);

  logic [3:0] sw_prev;
  logic [3:0] pend;
  logic [3:0] pend_nxt;
  logic [3:0] press;
  logic [3:0] acc_mask;
  logic [1:0] rr_ptr;
  logic [1:0] dir;
  logic       valid;
  logic       acc;

  // Round-robin: first requester at or after ptr, wrapping.
  function automatic logic [1:0] arb(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    logic [1:0] idx;
    logic [1:0] g;
    g = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) g = idx;
    end
    return g;
  endfunction

  assign press    = i_Switch & ~sw_prev;
  assign acc      = valid & mv.i_Move_Ready;
  assign acc_mask = acc ? (4'b0001 << dir) : 4'b0000;

  assign mv.o_Move_Valid = valid;
  assign mv.o_Move_Dir   = dir;
  assign o_Pending       = pend;

`ifdef AUTO_REPEAT_EN

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last_dir;
  logic             rep;
  logic             rpt_set;

  assign rpt_set = (state == HOLD) &&
                   (pend == 4'b0000) &&
                   i_Switch[last_dir] &&
                   (cnt == '0);

  assign mv.o_Move_Repeat = rep;

  // A fresh press on the accepted bit survives the clear.
  always_comb begin
    pend_nxt = 4'b0000;
    if (i_Enable)
      pend_nxt = (pend & ~acc_mask) | press |
                 ({3'b000, rpt_set} << last_dir);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sw_prev  <= 4'b0000;
      pend     <= 4'b0000;
      rr_ptr   <= 2'd0;
      dir      <= 2'd0;
      valid    <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      last_dir <= 2'd0;
      rep      <= 1'b0;
    end else begin
      sw_prev <= i_Switch;
      pend    <= pend_nxt;
      if (!i_Enable) begin
        state <= IDLE;
        valid <= 1'b0;
        rep   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (|pend) begin
              state <= OFFER;
              valid <= 1'b1;
              dir   <= arb(pend, rr_ptr);
              rep   <= 1'b0;
            end
          end
          OFFER: begin
            if (acc) begin
              rr_ptr   <= dir + 2'd1;
              last_dir <= dir;
              cnt      <= rep ? CNT_W'(REPEAT_RATE - 1)
                              : CNT_W'(REPEAT_DELAY - 1);
              state    <= HOLD;
              valid    <= 1'b0;
            end
          end
          HOLD: begin
            if (|pend) begin
              state <= OFFER;
              valid <= 1'b1;
              dir   <= arb(pend, rr_ptr);
              rep   <= 1'b0;
            end else if (!i_Switch[last_dir]) begin
              state <= IDLE;
            end else if (cnt == '0) begin
              state <= OFFER;
              valid <= 1'b1;
              dir   <= last_dir;
              rep   <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`else

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t     state;
  logic [3:0] rem;
  logic       unused_cfg;

  assign unused_cfg = ^{REPEAT_DELAY, REPEAT_RATE, CNT_W};
  assign rem        = pend & ~acc_mask;

  assign mv.o_Move_Repeat = 1'b0;

  always_comb begin
    pend_nxt = 4'b0000;
    if (i_Enable)
      pend_nxt = rem | press;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sw_prev <= 4'b0000;
      pend    <= 4'b0000;
      rr_ptr  <= 2'd0;
      dir     <= 2'd0;
      valid   <= 1'b0;
      state   <= IDLE;
    end else begin
      sw_prev <= i_Switch;
      pend    <= pend_nxt;
      if (!i_Enable) begin
        state <= IDLE;
        valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (|pend) begin
              state <= OFFER;
              valid <= 1'b1;
              dir   <= arb(pend, rr_ptr);
            end
          end
          OFFER: begin
            if (acc) begin
              rr_ptr <= dir + 2'd1;
              // Chain straight into the next queued move.
              if (|rem) begin
                dir <= arb(rem, dir + 2'd1);
              end else begin
                state <= IDLE;
                valid <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`endif

endmodule

// File: tb/tb_move_request_arbiter.sv
// Directed bench for move_request_arbiter (REPEAT_DELAY=8, REPEAT_RATE=4).
// Expectations follow AUTO_REPEAT_EN as seen by this compilation.
module tb_move_request_arbiter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b1;
  logic [3:0] sw    = 4'b0000;
  logic [3:0] pend;

  int         total  = 0;
  int         passed = 0;
  int         n;
  int         cnt;
  logic [1:0] d;
  logic       r;
  logic       ok;

`ifdef AUTO_REPEAT_EN
  localparam int BACK = 2;
`else
  localparam int BACK = 1;
`endif

  move_request_arbiter_if mv ();

  move_request_arbiter #(
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (4),
    .CNT_W        (24)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Switch  (sw),
    .i_Enable  (en),
    .mv        (mv),
    .o_Pending (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int k);
    repeat (k) step();
  endtask

  task automatic wait_acc(
    input  int         max,
    output int         n_o,
    output logic [1:0] d_o,
    output logic       r_o,
    output logic       ok_o
  );
    n_o  = 0;
    ok_o = 1'b0;
    d_o  = 2'd0;
    r_o  = 1'b0;
    while (!ok_o && n_o < max) begin
      if (mv.o_Move_Valid && mv.i_Move_Ready) begin
        d_o  = mv.o_Move_Dir;
        r_o  = mv.o_Move_Repeat;
        ok_o = 1'b1;
      end
      step();
      n_o++;
    end
  endtask

  task automatic count_valid(input int k, output int c);
    c = 0;
    repeat (k) begin
      step();
      c += int'(mv.o_Move_Valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    mv.i_Move_Ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(mv.o_Move_Valid), 32'd0);
    chk("rst_dir", 32'(mv.o_Move_Dir), 32'd0);
    chk("rst_rep", 32'(mv.o_Move_Repeat), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single tap on up
    sw = 4'b0001;
    mv.i_Move_Ready = 1'b1;
    step();
    chk("tap_pend", 32'(pend), 32'h1);
    chk("tap_early", 32'(mv.o_Move_Valid), 32'd0);
    step();
    chk("tap_valid", 32'(mv.o_Move_Valid), 32'd1);
    chk("tap_dir", 32'(mv.o_Move_Dir), 32'd0);
    chk("tap_rep", 32'(mv.o_Move_Repeat), 32'd0);
    step();
    chk("tap_drop", 32'(mv.o_Move_Valid), 32'd0);
    chk("tap_clr", 32'(pend), 32'd0);
    sw = 4'b0000;
    count_valid(12, cnt);
    chk("tap_none", 32'(cnt), 32'd0);

    // simultaneous down+right, then up+down
    sw = 4'b1010;
    wait_acc(20, n, d, r, ok);
    chk("sim1_ok", 32'(ok), 32'd1);
    chk("sim1_lat", 32'(n), 32'd3);
    chk("sim1_dir", 32'(d), 32'd1);
    sw = 4'b0000;
    wait_acc(20, n, d, r, ok);
    chk("sim2_lat", 32'(n), 32'(BACK));
    chk("sim2_dir", 32'(d), 32'd3);
    sw = 4'b0011;
    wait_acc(20, n, d, r, ok);
    chk("sim3_lat", 32'(n), 32'd3);
    chk("sim3_dir", 32'(d), 32'd0);
    sw = 4'b0000;
    wait_acc(20, n, d, r, ok);
    chk("sim4_lat", 32'(n), 32'(BACK));
    chk("sim4_dir", 32'(d), 32'd1);
    steps(3);

    // backpressure on left, up pressed during stall
    mv.i_Move_Ready = 1'b0;
    sw = 4'b0100;
    steps(2);
    chk("bp_valid", 32'(mv.o_Move_Valid), 32'd1);
    chk("bp_dir", 32'(mv.o_Move_Dir), 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) sw = 4'b0101;
      step();
      chk("bp_hold_v", 32'(mv.o_Move_Valid), 32'd1);
      chk("bp_hold_d", 32'(mv.o_Move_Dir), 32'd2);
    end
    chk("bp_pend", 32'(pend), 32'h5);
    mv.i_Move_Ready = 1'b1;
    sw = 4'b0000;
    wait_acc(20, n, d, r, ok);
    chk("bp_acc_lat", 32'(n), 32'd1);
    chk("bp_acc_dir", 32'(d), 32'd2);
    wait_acc(20, n, d, r, ok);
    chk("bp_up_lat", 32'(n), 32'(BACK));
    chk("bp_up_dir", 32'(d), 32'd0);
    chk("bp_up_rep", 32'(r), 32'd0);
    steps(3);

    // hold right
    sw = 4'b1000;
    wait_acc(20, n, d, r, ok);
    chk("hold_lat", 32'(n), 32'd3);
    chk("hold_dir", 32'(d), 32'd3);
    chk("hold_rep", 32'(r), 32'd0);
`ifdef AUTO_REPEAT_EN
    wait_acc(30, n, d, r, ok);
    chk("rpt1_gap", 32'(n), 32'd9);
    chk("rpt1_dir", 32'(d), 32'd3);
    chk("rpt1_rep", 32'(r), 32'd1);
    for (int i = 0; i < 2; i++) begin
      wait_acc(30, n, d, r, ok);
      chk("rptn_gap", 32'(n), 32'd5);
      chk("rptn_dir", 32'(d), 32'd3);
      chk("rptn_rep", 32'(r), 32'd1);
    end
    sw = 4'b0000;
    count_valid(20, cnt);
    chk("rpt_release", 32'(cnt), 32'd0);
`else
    count_valid(30, cnt);
    chk("norpt_once", 32'(cnt), 32'd0);
    sw = 4'b0000;
`endif
    steps(3);

    // disable while stalled
    mv.i_Move_Ready = 1'b0;
    sw = 4'b0010;
    steps(2);
    chk("dis_valid", 32'(mv.o_Move_Valid), 32'd1);
    chk("dis_dir", 32'(mv.o_Move_Dir), 32'd1);
    en = 1'b0;
    step();
    chk("dis_drop", 32'(mv.o_Move_Valid), 32'd0);
    chk("dis_pend", 32'(pend), 32'd0);
    sw = 4'b0110;
    step();
    chk("dis_press", 32'(pend), 32'd0);
    step();
    en = 1'b1;
    mv.i_Move_Ready = 1'b1;
    count_valid(10, cnt);
    chk("dis_never", 32'(cnt), 32'd0);
    sw = 4'b0000;
    steps(3);

    // reset in the middle of an offer
    sw = 4'b0010;
    wait_acc(20, n, d, r, ok);
    chk("pre_dir", 32'(d), 32'd1);
    sw = 4'b0000;
    steps(3);
    mv.i_Move_Ready = 1'b0;
    sw = 4'b1000;
    steps(2);
    chk("mid_valid", 32'(mv.o_Move_Valid), 32'd1);
    chk("mid_dir", 32'(mv.o_Move_Dir), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(mv.o_Move_Valid), 32'd0);
    chk("arst_dir", 32'(mv.o_Move_Dir), 32'd0);
    chk("arst_rep", 32'(mv.o_Move_Repeat), 32'd0);
    chk("arst_pend", 32'(pend), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sw = 4'b1001;
    mv.i_Move_Ready = 1'b1;
    wait_acc(20, n, d, r, ok);
    chk("post_lat", 32'(n), 32'd3);
    chk("post_dir", 32'(d), 32'd0);
    sw = 4'b0000;
    wait_acc(20, n, d, r, ok);
    chk("post2_dir", 32'(d), 32'd3);
    steps(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
